// File: rtl/arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int NREQ = 16;
    localparam int IDW  = 4;

endpackage

// File: rtl/pri_enc16_lsb.sv
// Lowest-index-wins priority encoder over 16 request lines.
// Latency: combinational, zero cycles.
// Backpressure: none; Dout is 0 and any is low when Din is empty.
module pri_enc16_lsb
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] Din,
    output logic [IDW-1:0]  Dout,
    output logic            any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        Dout = '0;
        any  = |Din;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (Din[i]) begin
                Dout = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter sharing one resource between 16 clients, with grant hold and watchdog.
// Latency: grant registered 1 cycle after req is sampled; at least 1 idle cycle between grants.
// Backpressure: none; grant is held until done, owner drops req, or MAX_HOLD cycles elapse.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 16
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            En,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid,
    output logic            timeout
);

    arb_state_t        state;
    logic [IDW-1:0]    ptr;
    logic [CNT_W-1:0]  hold_cnt;

    logic [NREQ-1:0]   masked;
    logic [IDW-1:0]    masked_id;
    logic [IDW-1:0]    raw_id;
    logic              masked_any;
    logic              raw_any;
    logic [IDW-1:0]    winner;
    logic              expire;
    logic              abandon;
    logic              release_now;

    // Requests at or above the pointer get first pick; otherwise wrap to the raw vector.
    always_comb begin
        masked = req & (16'hFFFF << ptr);
    end

    pri_enc16_lsb u_enc_masked (
        .Din  (masked),
        .Dout (masked_id),
        .any  (masked_any)
    );

    pri_enc16_lsb u_enc_raw (
        .Din  (req),
        .Dout (raw_id),
        .any  (raw_any)
    );

    // Winner selection and the three release causes for the current owner.
    always_comb begin
        winner      = masked_any ? masked_id : raw_id;
        expire      = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        abandon     = ~req[grant_id];
        release_now = done | abandon | expire;
    end

    // Two-state FSM; every output is a register so grant_id can drive a mux directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (En && raw_any) begin
                        state       <= GRANT;
                        grant       <= NREQ'(1) << winner;
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_id    <= '0;
                        grant_valid <= 1'b0;
                        hold_cnt    <= '0;
                        ptr         <= grant_id + 1'b1;
                        // A watchdog pulse only when expiry alone ended the grant.
                        timeout     <= expire & ~done & ~abandon;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 with a short watchdog.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_rr_arbiter16;
    import arb_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [15:0]     req;
    logic            done;
    logic [15:0]     grant;
    logic [3:0]      grant_id;
    logic            grant_valid;
    logic            timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] req;
        logic        en;
        logic        vld;
        logic [3:0]  id;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [3:0] id;
    } exp_t;

    vec_t tbl[10];
    exp_t sb[$];

    rr_arbiter16 #(.MAX_HOLD(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .En          (en),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic vld, input logic [3:0] id);
        exp_t e;
        e.vld = vld;
        e.id  = id;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic expect_grant(input string nm);
        exp_t e;
        logic [15:0] onehot;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_valid"}, 32'(grant_valid), 32'(e.vld));
            if (e.vld) begin
                onehot = 16'h0001 << e.id;
                check({nm, "_id"}, 32'(grant_id), 32'(e.id));
                check({nm, "_grant"}, 32'(grant), 32'(onehot));
            end else begin
                check({nm, "_grant"}, 32'(grant), 32'h0);
            end
        end
    endtask

    initial begin
        // Expected ids worked out by hand from the rotation pointer left by the previous row.
        tbl[0] = '{req: 16'h0001, en: 1'b1, vld: 1'b1, id: 4'd0};
        tbl[1] = '{req: 16'h8101, en: 1'b1, vld: 1'b1, id: 4'd8};
        tbl[2] = '{req: 16'h0104, en: 1'b1, vld: 1'b1, id: 4'd2};
        tbl[3] = '{req: 16'hFFFF, en: 1'b0, vld: 1'b0, id: 4'd0};
        tbl[4] = '{req: 16'h0006, en: 1'b1, vld: 1'b1, id: 4'd1};
        tbl[5] = '{req: 16'h8000, en: 1'b1, vld: 1'b1, id: 4'd15};
        tbl[6] = '{req: 16'h8001, en: 1'b1, vld: 1'b1, id: 4'd0};
        tbl[7] = '{req: 16'h0000, en: 1'b1, vld: 1'b0, id: 4'd0};
        tbl[8] = '{req: 16'hFFFE, en: 1'b1, vld: 1'b1, id: 4'd1};
        tbl[9] = '{req: 16'h0003, en: 1'b1, vld: 1'b1, id: 4'd0};

        rst_n = 1'b0;
        en    = 1'b1;
        req   = 16'h0;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_id", 32'(grant_id), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // Rotation with req held: one idle cycle between consecutive grants.
        @(negedge clk);
        req = 16'h8101;
        foreach (tbl[k]) begin end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ids [4];
            ids = '{4'd0, 4'd8, 4'd15, 4'd0};
            push(1'b1, ids[i]);
            @(negedge clk);
            expect_grant($sformatf("rot%0d", i));
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check($sformatf("rot%0d_gap", i), 32'(grant_valid), 32'h0);
        end
        req = 16'h0;
        @(negedge clk);

        // Table: one arbitration per row, released by done.
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            en  = tbl[i].en;
            push(tbl[i].vld, tbl[i].id);
            @(negedge clk);
            expect_grant($sformatf("vec%0d", i));
            if (tbl[i].vld) begin
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
                check($sformatf("vec%0d_rel", i), 32'(grant_valid), 32'h0);
            end
            req = 16'h0;
            en  = 1'b1;
            @(negedge clk);
        end

        // Watchdog: MAX_HOLD=4 cycles of grant, then a one-cycle timeout and re-grant.
        req = 16'h0010;
        push(1'b1, 4'd4);
        @(negedge clk);
        expect_grant("wd_first");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wd_hold%0d", i), 32'(grant_valid), 32'h1);
            check($sformatf("wd_to%0d", i), 32'(timeout), 32'h0);
        end
        @(negedge clk);
        check("wd_rel_valid", 32'(grant_valid), 32'h0);
        check("wd_pulse", 32'(timeout), 32'h1);
        push(1'b1, 4'd4);
        @(negedge clk);
        expect_grant("wd_regrant");
        check("wd_pulse_end", 32'(timeout), 32'h0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 16'h0;
        check("wd_done_rel", 32'(grant_valid), 32'h0);

        // Owner abandons its request: release without timeout.
        @(negedge clk);
        req = 16'h0020;
        push(1'b1, 4'd5);
        @(negedge clk);
        expect_grant("ab_grant");
        req = 16'h0;
        @(negedge clk);
        check("ab_valid", 32'(grant_valid), 32'h0);
        check("ab_timeout", 32'(timeout), 32'h0);

        // done coinciding with expiry is a normal release; En low mid-grant does not revoke.
        @(negedge clk);
        req = 16'h0040;
        push(1'b1, 4'd6);
        @(negedge clk);
        expect_grant("co_grant");
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("co_hold_en0", 32'(grant_valid), 32'h1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        en   = 1'b1;
        req  = 16'h0;
        check("co_valid", 32'(grant_valid), 32'h0);
        check("co_timeout", 32'(timeout), 32'h0);

        // Asynchronous reset mid-grant clears outputs at once and resets the pointer.
        @(negedge clk);
        req = 16'h0100;
        push(1'b1, 4'd8);
        @(negedge clk);
        expect_grant("ar_grant");
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant_clr", 32'(grant), 32'h0);
        check("ar_valid_clr", 32'(grant_valid), 32'h0);
        #1 rst_n = 1'b1;
        req = 16'h0402;
        push(1'b1, 4'd1);
        @(negedge clk);
        expect_grant("ar_ptr0");
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 16'h0;
        check("ar_rel", 32'(grant_valid), 32'h0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout_guard: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
